// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronise and debounce quadrature channels A/B, emit up/down/err step pulses
// Ports: clk, reset (sync, active-high), en (pulse enable), enc_a/enc_b (raw channels),
//   err_clr (clears err_sticky); up/down/err (one-cycle pulses), err_sticky, ab_state (debounced {a,b}),
//   ready (initial state captured).
module quad_step_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       err_clr,
  output logic       up,
  output logic       down,
  output logic       err,
  output logic       err_sticky,
  output logic [1:0] ab_state,
  output logic       ready
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, filt, prev_ab, init_cnt;
  logic [1:0][DB_W-1:0] db_cnt;
  logic fwd, rev, ill;
  // Gray order 00 -> 01 -> 11 -> 10 is forward; successor/predecessor derived from prev_ab bits
  always_comb begin
    state_n = (state == INIT && init_cnt == 2'd2) ? RUN : state;
    fwd = filt == {prev_ab[0], ~prev_ab[1]};
    rev = filt == {~prev_ab[0], prev_ab[1]};
    ill = &(filt ^ prev_ab);
  end
  always_ff @(posedge clk) state <= reset ? INIT : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      prev_ab <= '0;
      init_cnt <= '0;
      db_cnt <= '0;
      up <= 1'b0;
      down <= 1'b0;
      err <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      s1 <= {enc_a, enc_b};
      s2 <= s1;
      up <= 1'b0;
      down <= 1'b0;
      err <= 1'b0;
      if (state == INIT) begin
        init_cnt <= init_cnt + 2'd1;
        if (state_n == RUN) begin
          filt <= s2;
          prev_ab <= s2;
        end
      end else begin
        for (int i = 0; i < 2; i++)
          if (s2[i] == filt[i]) db_cnt[i] <= '0;
          else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt[i] <= s2[i];
            db_cnt[i] <= '0;
          end else db_cnt[i] <= db_cnt[i] + 1'b1;
        prev_ab <= filt;
        up <= en & fwd;
        down <= en & rev;
        err <= en & ill;
        err_sticky <= (en & ill) | (err_sticky & ~err_clr);
      end
    end
  end
  assign ab_state = filt;
  assign ready = state == RUN;
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed checks of the quadrature step decoder
module tb_quad_step_decoder;
  logic clk = 1'b0, reset = 1'b1, en = 1'b1, enc_a = 1'b1, enc_b = 1'b1, err_clr = 1'b0;
  logic up, down, err, err_sticky, ready;
  logic [1:0] ab_state;
  logic [2:0] stub;
  int total = 0, bad = 0, n_up, n_dn, n_err, first;
  always #5 clk = ~clk;
  quad_step_decoder dut (
    .clk(clk), .reset(reset), .en(en), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .up(up), .down(down), .err(err), .err_sticky(err_sticky), .ab_state(ab_state), .ready(ready)
  );
  always_ff @(posedge clk) stub <= reset ? 3'd0 : up ? stub + 3'd1 : down ? stub - 3'd1 : stub;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    n_up = 0;
    n_dn = 0;
    n_err = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      tick;
      if (up) n_up++;
      if (down) n_dn++;
      if (err) n_err++;
      if ((up | down | err) && first == 0) first = i;
    end
  endtask
  task automatic step(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    run(10);
  endtask
  task automatic check_step(input string tag, input int eu, input int ed, input int ee, input int eab);
    chk({tag, "_up"}, n_up, eu);
    chk({tag, "_down"}, n_dn, ed);
    chk({tag, "_err"}, n_err, ee);
    chk({tag, "_lat"}, first, (eu + ed + ee) != 0 ? 7 : 0);
    chk({tag, "_ab"}, int'(ab_state), eab);
  endtask
  task automatic restart(input logic a, input logic b);
    reset = 1'b1;
    enc_a = a;
    enc_b = b;
    tick;
    tick;
    reset = 1'b0;
    tick;
    tick;
    tick;
    chk("restart_ready", int'(ready), 1);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_ready", int'(ready), 0);
    chk("rst_ab", int'(ab_state), 0);
    chk("rst_pulses", int'(up) + int'(down) + int'(err), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    reset = 1'b0;
    tick;
    chk("init_e1", int'(ready), 0);
    tick;
    chk("init_e2", int'(ready), 0);
    tick;
    chk("init_e3", int'(ready), 1);
    chk("init_ab", int'(ab_state), 3);
    run(10);
    chk("init_quiet", n_up + n_dn + n_err, 0);
    chk("init_sticky", int'(err_sticky), 0);
    restart(1'b0, 1'b0);
    chk("fwd_start_ab", int'(ab_state), 0);
    step(1'b0, 1'b1);
    check_step("fwd1", 1, 0, 0, 1);
    step(1'b1, 1'b1);
    check_step("fwd2", 1, 0, 0, 3);
    step(1'b1, 1'b0);
    check_step("fwd3", 1, 0, 0, 2);
    step(1'b0, 1'b0);
    check_step("fwd4", 1, 0, 0, 0);
    chk("fwd_stub", int'(stub), 4);
    restart(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_step("rev1", 0, 1, 0, 2);
    chk("rev_wrap", int'(stub), 7);
    step(1'b1, 1'b1);
    check_step("rev2", 0, 1, 0, 3);
    step(1'b0, 1'b1);
    check_step("rev3", 0, 1, 0, 1);
    step(1'b0, 1'b0);
    check_step("rev4", 0, 1, 0, 0);
    chk("rev_stub", int'(stub), 4);
    enc_b = 1'b1;
    tick;
    tick;
    tick;
    enc_b = 1'b0;
    run(12);
    check_step("glitch", 0, 0, 0, 0);
    step(1'b0, 1'b1);
    check_step("deb4", 1, 0, 0, 1);
    step(1'b0, 1'b0);
    check_step("ill_pre", 0, 1, 0, 0);
    step(1'b1, 1'b1);
    check_step("ill1", 0, 0, 1, 3);
    chk("ill1_sticky", int'(err_sticky), 1);
    enc_a = 1'b0;
    enc_b = 1'b0;
    run(6);
    chk("ill2_early", n_up + n_dn + n_err, 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("ill2_err", int'(err), 1);
    chk("ill2_set_wins", int'(err_sticky), 1);
    run(5);
    chk("ill2_hold", int'(err_sticky), 1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("clr_sticky", int'(err_sticky), 0);
    chk("clr_ab", int'(ab_state), 0);
    en = 1'b0;
    step(1'b0, 1'b1);
    chk("en0_a", n_up + n_dn + n_err, 0);
    step(1'b1, 1'b1);
    chk("en0_b", n_up + n_dn + n_err, 0);
    chk("en0_ab", int'(ab_state), 3);
    en = 1'b1;
    run(10);
    chk("reen_burst", n_up + n_dn + n_err, 0);
    step(1'b1, 1'b0);
    check_step("reen", 1, 0, 0, 2);
    enc_a = 1'b0;
    enc_b = 1'b0;
    run(6);
    chk("mid_early", n_up, 0);
    reset = 1'b1;
    tick;
    chk("mid_up", int'(up), 0);
    chk("mid_ready", int'(ready), 0);
    chk("mid_ab", int'(ab_state), 0);
    reset = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
